div_iter: RTL and testbench

Iterative radix-2 integer divider for the RISC-V M-extension DIV/DIVU/REM/REMU operations. It is the inverse-operation companion to the pipelined multiplier in the MDU. The issuing logic presents operands in Execute and holds the instruction until completion. The block produces one quotient bit per cycle and handles the RISC-V divide-by-zero and signed-overflow cases in a single cycle.

---
 rtl/div_iter_pkg.sv | 23 ++
 rtl/div_step.sv | 28 ++
 rtl/div_iter.sv | 116 +++++++++++
 tb/tb_div_iter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_iter_pkg.sv
// Shared types and helpers for the iterative radix-2 divider.
package div_iter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  function automatic logic is_signed(input logic [2:0] f3);
    return ~f3[0];
  endfunction

  function automatic logic is_rem(input logic [2:0] f3);
    return f3[1];
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, trial-subtract |B|.
module div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN:0]   r,
  input  logic [XLEN-1:0] q,
  input  logic [XLEN-1:0] b,
  output logic [XLEN:0]   r_next,
  output logic [XLEN-1:0] q_next
);

  // One guard bit above R so the trial difference carries its own sign.
  logic [XLEN+1:0] rs;
  logic [XLEN+1:0] d;

  always_comb begin
    rs = {r, q[XLEN-1]};
    d  = rs - {2'b00, b};
    if (!d[XLEN+1]) begin
      r_next = d[XLEN:0];
      q_next = {q[XLEN-2:0], 1'b1};
    end else begin
      r_next = rs[XLEN:0];
      q_next = {q[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 divider for DIV/DIVU/REM/REMU with single-cycle special cases.
//   state  | meaning
//   S_IDLE | waiting for StartE
//   S_BUSY | one quotient bit per cycle, counter XLEN-1 down to 0
//   S_DONE | DoneM pulse, DivResultM freshly loaded; may accept a new start
module div_iter
  import div_iter_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            FlushE,
  input  logic            StartE,
  input  logic [XLEN-1:0] ForwardedSrcAE,
  input  logic [XLEN-1:0] ForwardedSrcBE,
  input  logic [2:0]      Funct3E,
  output logic            BusyE,
  output logic            DoneM,
  output logic [XLEN-1:0] DivResultM
);

  localparam int CW = $clog2(XLEN);

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic [XLEN:0]   r, r_nx;
  logic [XLEN-1:0] q, q_nx, absb, result;
  logic [2:0]      f3;
  logic            nega, negb;

  logic            accept, step, sgn_in, div_zero, ovf, special;
  logic [XLEN-1:0] abs_a_in, abs_b_in, special_res, qf, rf, fixed;

  assign accept = StartE && !FlushE && (state != S_BUSY);
  assign step   = (state == S_BUSY) && !FlushE;

  always_comb begin
    sgn_in   = is_signed(Funct3E);
    abs_a_in = (sgn_in && ForwardedSrcAE[XLEN-1]) ? -ForwardedSrcAE : ForwardedSrcAE;
    abs_b_in = (sgn_in && ForwardedSrcBE[XLEN-1]) ? -ForwardedSrcBE : ForwardedSrcBE;
    div_zero = (ForwardedSrcBE == '0);
    ovf      = sgn_in && (ForwardedSrcAE == {1'b1, {(XLEN-1){1'b0}}}) && (ForwardedSrcBE == '1);
    special  = div_zero || ovf;
    if (div_zero) special_res = is_rem(Funct3E) ? ForwardedSrcAE : '1;
    else          special_res = is_rem(Funct3E) ? '0 : ForwardedSrcAE;
  end

  div_step #(.XLEN(XLEN)) u_step (
    .r      (r),
    .q      (q),
    .b      (absb),
    .r_next (r_nx),
    .q_next (q_nx)
  );

  // Sign fixup on the final step's outputs so the result register loads once.
  always_comb begin
    qf    = q_nx;
    rf    = r_nx[XLEN-1:0];
    fixed = is_rem(f3) ? (nega ? -rf : rf) : ((nega ^ negb) ? -qf : qf);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (FlushE) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (accept) state_n = special ? S_DONE : S_BUSY;
        S_BUSY:  if (cnt == '0) state_n = S_DONE;
        S_DONE:  state_n = accept ? (special ? S_DONE : S_BUSY) : S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_comb begin
    BusyE      = (state == S_BUSY);
    DoneM      = (state == S_DONE);
    DivResultM = result;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r      <= '0;
      q      <= '0;
      absb   <= '0;
      cnt    <= '0;
      f3     <= '0;
      nega   <= 1'b0;
      negb   <= 1'b0;
      result <= '0;
    end else if (accept) begin
      r    <= '0;
      q    <= abs_a_in;
      absb <= abs_b_in;
      cnt  <= CW'(XLEN-1);
      f3   <= Funct3E;
      nega <= sgn_in && ForwardedSrcAE[XLEN-1];
      negb <= sgn_in && ForwardedSrcBE[XLEN-1];
      if (special) result <= special_res;
    end else if (step) begin
      r   <= r_nx;
      q   <= q_nx;
      cnt <= cnt - 1'b1;
      if (cnt == '0) result <= fixed;
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter at XLEN=32: latency, results, special cases, flush, reset.
module tb_div_iter;
  import div_iter_pkg::*;

  logic        clk = 1'b0;
  logic        reset, FlushE, StartE;
  logic [31:0] ForwardedSrcAE, ForwardedSrcBE;
  logic [2:0]  Funct3E;
  logic        BusyE, DoneM;
  logic [31:0] DivResultM;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  div_iter #(.XLEN(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .FlushE         (FlushE),
    .StartE         (StartE),
    .ForwardedSrcAE (ForwardedSrcAE),
    .ForwardedSrcBE (ForwardedSrcBE),
    .Funct3E        (Funct3E),
    .BusyE          (BusyE),
    .DoneM          (DoneM),
    .DivResultM     (DivResultM)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic sg, rm;
    sg = ~f3[0];
    rm = f3[1];
    if (b == 0) return rm ? a : 32'hFFFFFFFF;
    if (sg && a == 32'h80000000 && b == 32'hFFFFFFFF) return rm ? 32'h0 : a;
    if (sg) return rm ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return rm ? a % b : a / b;
  endfunction

  // Called at a negedge: drive the start for one edge, then scramble the operands.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    StartE = 1'b1;
    Funct3E = f3;
    ForwardedSrcAE = a;
    ForwardedSrcBE = b;
    @(posedge clk);
    #1;
    StartE = 1'b0;
    ForwardedSrcAE = $urandom;
    ForwardedSrcBE = $urandom;
    Funct3E = 3'(4 + $urandom_range(0, 3));
  endtask

  // Returns at the negedge of the DoneM cycle (or after the cycle budget).
  task automatic expect_done(input int lat, input int poke, input string name);
    bit busy_ok = 1'b1;
    bit seen = 1'b0;
    int n_done = 0;
    logic [31:0] e;
    for (int n = 1; n <= 80 && !seen; n++) begin
      @(negedge clk);
      if (BusyE !== (n < lat ? 1'b1 : 1'b0)) busy_ok = 1'b0;
      if (DoneM === 1'b1) begin
        seen = 1'b1;
        n_done = n;
        total++;
        if (n_done != lat) begin
          bad++;
          $display("FAIL %s latency: got %0d want %0d", name, n_done, lat);
        end
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL %s result: scoreboard empty, got %h", name, DivResultM);
        end else begin
          e = exp_q.pop_front();
          if (DivResultM !== e) begin
            bad++;
            $display("FAIL %s result: got %h want %h", name, DivResultM, e);
          end
        end
      end
      StartE = (n == poke);
      if (n == poke) begin
        Funct3E = F3_DIVU;
        ForwardedSrcAE = 32'd1000;
        ForwardedSrcBE = 32'd0;
      end
    end
    StartE = 1'b0;
    total++;
    if (!busy_ok) begin
      bad++;
      $display("FAIL %s busy pattern: BusyE wrong before DoneM (want busy for cycles 1..%0d)", name, lat - 1);
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s timeout: no DoneM within 80 cycles, want at %0d", name, lat);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e, input int lat, input string name);
    @(negedge clk);
    exp_q.push_back(e);
    issue(f3, a, b);
    expect_done(lat, 0, name);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    total++;
    if (BusyE !== 1'b0 || DoneM !== 1'b0 || DivResultM !== 32'h0) begin
      bad++;
      $display("FAIL reset_state: busy=%b done=%b res=%h want 0 0 00000000", BusyE, DoneM, DivResultM);
    end
  endtask

  task automatic test_unsigned;
    run_op(F3_REMU, 32'd100, 32'd7, 32'd2, 33, "remu_100_7");
    run_op(F3_DIVU, 32'd100, 32'd7, 32'd14, 33, "divu_100_7");
    @(negedge clk);
    total++;
    if (DoneM !== 1'b0 || BusyE !== 1'b0 || DivResultM !== 32'd14) begin
      bad++;
      $display("FAIL done_pulse_hold: done=%b busy=%b res=%h want 0 0 0000000e", DoneM, BusyE, DivResultM);
    end
  endtask

  task automatic test_signed;
    run_op(F3_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, "div_m7_2");
    run_op(F3_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, "rem_m7_2");
    run_op(F3_DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33, "div_7_m2");
  endtask

  task automatic test_special;
    run_op(F3_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1, "divu_5_0");
    run_op(F3_REMU, 32'd5, 32'd0, 32'd5, 1, "remu_5_0");
    run_op(F3_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 1, "div_m7_0");
    run_op(F3_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_ovf");
    run_op(F3_REM, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, "rem_ovf");
  endtask

  task automatic test_flush;
    bit any_done = 1'b0;
    run_op(F3_DIVU, 32'd100, 32'd7, 32'd14, 33, "flush_prior");
    @(negedge clk);
    issue(F3_DIVU, 32'd200, 32'd3);
    repeat (9) @(negedge clk);
    @(negedge clk);
    FlushE = 1'b1;
    StartE = 1'b1;
    Funct3E = F3_DIVU;
    ForwardedSrcAE = 32'd5;
    ForwardedSrcBE = 32'd0;
    @(posedge clk);
    #1;
    FlushE = 1'b0;
    StartE = 1'b0;
    @(negedge clk);
    total++;
    if (BusyE !== 1'b0 || DoneM !== 1'b0 || DivResultM !== 32'd14) begin
      bad++;
      $display("FAIL flush_cycle11: busy=%b done=%b res=%h want 0 0 0000000e", BusyE, DoneM, DivResultM);
    end
    repeat (40) begin
      @(negedge clk);
      if (DoneM === 1'b1 || DivResultM !== 32'd14) any_done = 1'b1;
    end
    total++;
    if (any_done) begin
      bad++;
      $display("FAIL flush_no_done: DoneM or result changed after flush, res=%h want 0000000e", DivResultM);
    end
    run_op(F3_DIVU, 32'd9, 32'd3, 32'd3, 33, "divu_9_3");
  endtask

  task automatic test_busy_start;
    @(negedge clk);
    exp_q.push_back(32'd42);
    issue(F3_DIVU, 32'd84, 32'd2);
    expect_done(33, 5, "busy_start_ignored");
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    exp_q.push_back(32'd33);
    issue(F3_DIVU, 32'd100, 32'd3);
    expect_done(33, 0, "b2b_first");
    exp_q.push_back(32'hFFFFFFFE);
    issue(F3_REM, 32'hFFFFFFF0, 32'd7);
    expect_done(33, 0, "b2b_second");
  endtask

  task automatic test_random;
    logic [2:0]  f3;
    logic [31:0] a, b;
    int lat;
    for (int i = 0; i < 8; i++) begin
      f3 = 3'(4 + $urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'h0;
        1: b = 32'($urandom_range(1, 100));
        2: b = $urandom;
        default: begin b = 32'hFFFFFFFF; a = 32'h80000000; end
      endcase
      lat = (b == 0 || (~f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)) ? 1 : 33;
      run_op(f3, a, b, ref_div(f3, a, b), lat, $sformatf("rand%0d_f%0d_%h_%h", i, f3, a, b));
    end
  endtask

  task automatic test_reset_mid;
    run_op(F3_DIVU, 32'd9, 32'd3, 32'd3, 33, "reset_prior");
    @(negedge clk);
    issue(F3_DIVU, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    total++;
    if (BusyE !== 1'b0 || DoneM !== 1'b0 || DivResultM !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid: busy=%b done=%b res=%h want 0 0 00000000", BusyE, DoneM, DivResultM);
    end
  endtask

  initial begin
    reset = 1'b0;
    FlushE = 1'b0;
    StartE = 1'b0;
    Funct3E = F3_DIVU;
    ForwardedSrcAE = '0;
    ForwardedSrcBE = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_flush();
    test_busy_start();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
